// File: rtl/icap_pkg.sv
`default_nettype none
// ============================================================================
// icap_pkg
// Shared ICAPE2 configuration words, register addresses and reader states.
// Revision: 1.0
// ============================================================================
package icap_pkg;

  localparam logic [31:0] c_dummy           = 32'hFFFF_FFFF;
  localparam logic [31:0] c_sync            = 32'hAA99_5566;
  localparam logic [31:0] c_noop            = 32'h2000_0000;
  localparam logic [31:0] c_type1_rd_base   = 32'h2800_0001;
  localparam logic [31:0] c_type1_wr_cmd    = 32'h3000_8001;
  localparam logic [31:0] c_cmd_desync      = 32'h0000_000D;
  localparam logic [31:0] c_cmd_iprog       = 32'h0000_000F;
  localparam logic [31:0] c_type1_wr_wbstar = 32'h3002_0001;

  localparam logic [4:0] c_addr_stat    = 5'h07;
  localparam logic [4:0] c_addr_idcode  = 5'h0C;
  localparam logic [4:0] c_addr_wbstar  = 5'h10;
  localparam logic [4:0] c_addr_bootsts = 5'h16;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'd0,
    ST_W_DUMMY  = 5'd1,
    ST_W_SYNC   = 5'd2,
    ST_W_NOP1   = 5'd3,
    ST_W_NOP2   = 5'd4,
    ST_W_RDHDR  = 5'd5,
    ST_W_NOP3   = 5'd6,
    ST_W_NOP4   = 5'd7,
    ST_TA1      = 5'd8,
    ST_TA2      = 5'd9,
    ST_RD_WAIT  = 5'd10,
    ST_TB1      = 5'd11,
    ST_TB2      = 5'd12,
    ST_W_CMDHDR = 5'd13,
    ST_W_DESYNC = 5'd14,
    ST_W_NOP5   = 5'd15,
    ST_W_NOP6   = 5'd16,
    ST_FINISH   = 5'd17
  } state_t;

  // Type-1 read header: one-word read of the addressed register (addr at [17:13]).
  function automatic logic [31:0] rd_header(input logic [4:0] addr);
    return c_type1_rd_base | {14'd0, addr, 13'd0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/icap_bitswap.sv
`default_nettype none
// ============================================================================
// icap_bitswap
// Per-byte bit reversal between natural word order and ICAPE2 bus order.
// Revision: 1.0
// ============================================================================
module icap_bitswap (
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    for (genvar k = 0; k < 8; k++) begin : g_bit
      assign o_data[8*b + k] = i_data[8*b + 7 - k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/icap_reg_reader.sv
`default_nettype none
// ============================================================================
// icap_reg_reader
// Reads one 7-series configuration register over ICAPE2 (sync, read, desync).
// Revision: 1.0
// ============================================================================
module icap_reg_reader
  import icap_pkg::*;
#(
  parameter int READ_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [4:0]  reg_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i,
  input  logic [31:0] icap_o
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_addr;
  logic [3:0]  r_wait_cnt;
  logic        w_wait_last;
  logic        w_csib_nxt;
  logic        w_rdwrb_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic [31:0] w_word_nxt;
  logic [31:0] w_icap_i_nxt;
  logic [31:0] w_rd_swapped;

  assign w_wait_last = (r_wait_cnt == 4'(READ_WAIT - 1));

  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:     w_state_nxt = req ? ST_W_DUMMY : ST_IDLE;
      ST_W_DUMMY:  w_state_nxt = ST_W_SYNC;
      ST_W_SYNC:   w_state_nxt = ST_W_NOP1;
      ST_W_NOP1:   w_state_nxt = ST_W_NOP2;
      ST_W_NOP2:   w_state_nxt = ST_W_RDHDR;
      ST_W_RDHDR:  w_state_nxt = ST_W_NOP3;
      ST_W_NOP3:   w_state_nxt = ST_W_NOP4;
      ST_W_NOP4:   w_state_nxt = ST_TA1;
      ST_TA1:      w_state_nxt = ST_TA2;
      ST_TA2:      w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT:  w_state_nxt = w_wait_last ? ST_TB1 : ST_RD_WAIT;
      ST_TB1:      w_state_nxt = ST_TB2;
      ST_TB2:      w_state_nxt = ST_W_CMDHDR;
      ST_W_CMDHDR: w_state_nxt = ST_W_DESYNC;
      ST_W_DESYNC: w_state_nxt = ST_W_NOP5;
      ST_W_NOP5:   w_state_nxt = ST_W_NOP6;
      ST_W_NOP6:   w_state_nxt = ST_FINISH;
      ST_FINISH:   w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the ICAP pins
  // are glitch-free and rdwrb only moves in the csib=1 turnaround states.
  always_comb begin
    w_csib_nxt  = 1'b1;
    w_rdwrb_nxt = 1'b0;
    w_word_nxt  = c_dummy;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      ST_IDLE:     w_busy_nxt = 1'b0;
      ST_W_DUMMY:  w_csib_nxt = 1'b0;
      ST_W_SYNC:   begin w_csib_nxt = 1'b0; w_word_nxt = c_sync;          end
      ST_W_NOP1,
      ST_W_NOP2,
      ST_W_NOP3,
      ST_W_NOP4,
      ST_W_NOP5,
      ST_W_NOP6:   begin w_csib_nxt = 1'b0; w_word_nxt = c_noop;          end
      ST_W_RDHDR:  begin w_csib_nxt = 1'b0; w_word_nxt = rd_header(r_addr); end
      ST_TA1:      w_rdwrb_nxt = 1'b0;
      ST_TA2:      w_rdwrb_nxt = 1'b1;
      ST_RD_WAIT:  begin w_csib_nxt = 1'b0; w_rdwrb_nxt = 1'b1;           end
      ST_TB1:      w_rdwrb_nxt = 1'b1;
      ST_TB2:      w_rdwrb_nxt = 1'b0;
      ST_W_CMDHDR: begin w_csib_nxt = 1'b0; w_word_nxt = c_type1_wr_cmd;  end
      ST_W_DESYNC: begin w_csib_nxt = 1'b0; w_word_nxt = c_cmd_desync;    end
      ST_FINISH:   w_done_nxt = 1'b1;
      default:     w_busy_nxt = 1'b0;
    endcase
  end

  icap_bitswap u_swap_wr (
    .i_data (w_word_nxt),
    .o_data (w_icap_i_nxt)
  );

  icap_bitswap u_swap_rd (
    .i_data (icap_o),
    .o_data (w_rd_swapped)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= 5'd0;
      r_wait_cnt <= 4'd0;
      icap_csib  <= 1'b1;
      icap_rdwrb <= 1'b0;
      icap_i     <= c_dummy;  // all-ones is its own bit swap
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_data    <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      icap_csib  <= w_csib_nxt;
      icap_rdwrb <= w_rdwrb_nxt;
      icap_i     <= w_icap_i_nxt;
      busy       <= w_busy_nxt;
      done       <= w_done_nxt;
      if (r_state == ST_IDLE && req) begin
        r_addr <= reg_addr;
      end
      if (r_state == ST_RD_WAIT && !w_wait_last) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end else begin
        r_wait_cnt <= 4'd0;
      end
      if (r_state == ST_RD_WAIT && w_wait_last) begin
        rd_data <= w_rd_swapped;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/icap_reg_reader.md
Name: icap_reg_reader

Overview:
- Reads one 32-bit 7-series configuration register (STAT, BOOTSTS, WBSTAR, IDCODE, ...) through the ICAPE2 port. It is the read-side companion of the IPROG/reprogram sequencer.
- It issues the UG470 Type-1 read sequence, turns the port around, captures the readback word, and then desyncs the configuration logic.
- It sits beside the reprogram block. The top level muxes the two onto the single ICAPE2, with ICAPE2 CLK = ~clk.
- Its purpose is to report boot status and the current WBSTAR to the IPbus register space.

Parameters:
- READ_WAIT, 4, number of cycles CSIB is held low with RDWRB=1 before icap_o is sampled (range 2..15).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req  in  1  start request, level- or pulse-sampled in IDLE only.
- reg_addr  in  5  configuration register address, latched when req is accepted.
- busy  out  1  high from the accept cycle through the done cycle.
- done  out  1  one-cycle pulse; rd_data is valid on the same cycle.
- rd_data  out  32  last captured register value (bit-swapped back to natural order); holds until the next capture.
- icap_csib  out  1  ICAP active-low enable.
- icap_rdwrb  out  1  ICAP read/write select (1 = read).
- icap_i  out  32  ICAP write data, already bit-swapped within each byte.
- icap_o  in  32  ICAP readback data, raw (bit-swapped within each byte).

Behaviour:
- Reset values (asserted asynchronously): state=IDLE, icap_csib=1, icap_rdwrb=0, icap_i=swap(FFFFFFFF), busy=0, done=0, rd_data=0.
- Bit swap: within each byte, bit k maps to bit 7-k. It is applied to every icap_i word and to icap_o before it is stored.
- IDLE: csib=1, rdwrb=0. If req=1 at an edge, latch reg_addr, set busy=1 and go to W_DUMMY.
- Write phase (csib=0, rdwrb=0), one word per cycle, in this order:
  - W_DUMMY FFFFFFFF
  - W_SYNC AA995566
  - W_NOP1 20000000
  - W_NOP2 20000000
  - W_RDHDR 28000001 | (addr<<13)
  - W_NOP3 20000000
  - W_NOP4 20000000
- Turnaround:
  - TA1: csib=1, rdwrb=0.
  - TA2: csib=1, rdwrb=1.
  - RDWRB never changes while csib=0. This is mandatory, to avoid an ICAP abort.
- RD_WAIT: csib=0, rdwrb=1, counter runs 0..READ_WAIT-1. On the edge ending the final wait cycle, rd_data <= swap(icap_o).
- Turnback:
  - TB1: csib=1, rdwrb=1.
  - TB2: csib=1, rdwrb=0.
- Desync phase (csib=0, rdwrb=0):
  - W_CMDHDR 30008001
  - W_DESYNC 0000000D
  - W_NOP5 20000000
  - W_NOP6 20000000
- FINISH: csib=1, icap_i=swap(FFFFFFFF), done=1, busy=1 for this cycle. The next state is IDLE with busy=0.
- Latency with READ_WAIT=4: done is asserted on cycle 20 after the accept edge (7 + 2 + 4 + 2 + 4 + 1). The general formula is 16+READ_WAIT.
- req while busy: ignored, not queued.
- reg_addr changes while busy: no effect, because the latched copy is used.
- req held high across FINISH: the block returns to IDLE for one cycle, then re-accepts. There is a minimum of one idle cycle between transactions.
- Reset mid-operation: immediate return to reset values and IDLE. rd_data is cleared and done is not pulsed. The configuration logic may be left synced; the next transaction resyncs it with DUMMY/SYNC.
- icap_i during csib=1 states: swap(FFFFFFFF).
- Illegal state encoding: recover to IDLE with reset values on outputs.

Decomposition:
- Shared package icap_pkg:
  - word constants: DUMMY, SYNC, NOOP, TYPE1_RD_BASE=28000001, TYPE1_WR_CMD=30008001, CMD_DESYNC=0000000D, CMD_IPROG=0000000F, TYPE1_WR_WBSTAR=30020001
  - register addresses: STAT=07, IDCODE=0C, WBSTAR=10, BOOTSTS=16
  - the state enumeration
- The package constants replace the per-file word definitions, so the reprogram block can adopt the package later.
- Sub-module icap_bitswap: purely combinational 32-bit per-byte bit reversal. It is instantiated twice, once for icap_i and once for icap_o.

Test Plan:
- Reset, then req with reg_addr=07 against an ICAP behavioural model. Required response:
  - icap_i sequence decodes to FFFFFFFF, AA995566, 20000000, 20000000, 2800E001, 20000000, 20000000, then 30008001, 0000000D, 20000000, 20000000.
  - done is asserted on cycle 20.
- Model returns swap(00000000_...) raw icap_o = swap(12345678) during RD_WAIT, with reg_addr=10 (header 28020001). Required response: rd_data=12345678 at done, and it holds after done falls.
- Checker on every edge: icap_rdwrb changes only while icap_csib=1, and csib is low for exactly 7, READ_WAIT, and 4 consecutive cycles per transaction.
- Pulse req again at cycles 3 and 18 of a transaction. Required response: no effect, exactly one done, busy stays high throughout.
- Assert reset low at cycle 11 (during RD_WAIT). Required response: outputs return to reset values before the next edge, rd_data=0, no done; a fresh req afterwards completes normally with reg_addr=16 (header 2802C001).
- Hold req=1 continuously. Required response: back-to-back transactions with exactly one IDLE cycle between FINISH and the next W_DUMMY.
- Run the full sequence with READ_WAIT=2 and READ_WAIT=15. Required response: done on cycles 18 and 31 respectively.
